muldiv_seq: RTL and testbench

- Multiply/divide step sequencer that drives the AMIN arithmetic card's control inputs. It runs unsigned 16x16 multiply and 32/16 divide as fixed-length shift/add sequences, and reads back the card's status (CO, AC0, AC15, SH0, SH15).
- It sits beside the microcode sequencer. While own=1, an external mux gives this block's control outputs priority over the microinstruction fields.
- The caller preloads A, AC and SH through the card before asserting start.

---
 rtl/muldiv_seq.sv | 194 +++++++++++++++++++
 tb/tb_muldiv_seq.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// Multiply/divide step sequencer for the AMIN arithmetic card.
// Runs unsigned NBITSxNBITS shift/add multiply and 2N/N restoring divide.
module muldiv_seq #(
   parameter int unsigned NBITS = 16
) (
   input  logic       clk,
   input  logic       MCL,
   input  logic       start,
   input  logic       op,
   input  logic       CO,
   input  logic       AC0,
   input  logic       AC15,
   input  logic       SH0,
   input  logic       SH15,
   output logic       own,
   output logic       busy,
   output logic       done,
   output logic       ovf,
   output logic       ACKL,
   output logic       SHKL,
   output logic       M,
   output logic       C,
   output logic       BC0,
   output logic       BC15,
   output logic       SHM,
   output logic       SHX,
   output logic [1:0] SHS,
   output logic [2:0] SL,
   output logic [3:0] S
);

   localparam int unsigned CntW = (NBITS > 1) ? $clog2(NBITS) : 1;

   typedef enum logic [3:0] {
      StIdle, StMclr, StMadd, StMshf, StDchk, StDshf, StDtrl, StDfin, StDone
   } state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   count_q, count_d;
   logic              carry_q, carry_d;
   logic              ext_q, ext_d;
   logic              q_q, q_d;
   logic              ovf_q, ovf_d;
   logic              last;

   assign last = (count_q == CntW'(NBITS - 1));

   always_ff @(posedge clk or posedge MCL) begin
      if (MCL) begin
         state_q <= StIdle;
         count_q <= '0;
         carry_q <= 1'b0;
         ext_q   <= 1'b0;
         q_q     <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         carry_q <= carry_d;
         ext_q   <= ext_d;
         q_q     <= q_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      carry_d = carry_q;
      ext_d   = ext_q;
      q_d     = q_q;
      ovf_d   = ovf_q;
      case (state_q)
         StIdle: begin
            if (start) begin
               ovf_d   = 1'b0;
               state_d = op ? StDchk : StMclr;
            end
         end
         StMclr: begin
            count_d = '0;
            state_d = StMadd;
         end
         StMadd: begin
            carry_d = SH0 & CO;
            state_d = StMshf;
         end
         StMshf: begin
            if (last) begin
               state_d = StDone;
            end else begin
               count_d = count_q + 1'b1;
               state_d = StMadd;
            end
         end
         StDchk: begin
            // AC >= A means the quotient cannot fit (also catches A = 0)
            if (CO) begin
               ovf_d   = 1'b1;
               state_d = StDone;
            end else begin
               count_d = '0;
               q_d     = 1'b0;
               state_d = StDshf;
            end
         end
         StDshf: begin
            ext_d   = AC15;
            state_d = StDtrl;
         end
         StDtrl: begin
            q_d = CO | ext_q;
            if (last) begin
               state_d = StDfin;
            end else begin
               count_d = count_q + 1'b1;
               state_d = StDshf;
            end
         end
         StDfin:  state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      ACKL = 1'b0;
      SHKL = 1'b0;
      M    = 1'b0;
      C    = 1'b0;
      BC0  = 1'b0;
      BC15 = 1'b0;
      SHM  = 1'b0;
      SHX  = 1'b0;
      SHS  = 2'b00;
      SL   = 3'd0;
      S    = 4'b0000;
      case (state_q)
         StMclr: begin
            M    = 1'b1;
            S    = 4'b1100;
            ACKL = 1'b1;
         end
         StMadd: begin
            SL   = 3'd3;
            S    = 4'b0001;
            ACKL = SH0;
         end
         StMshf: begin
            SL   = 3'd4;
            BC0  = carry_q;
            M    = 1'b1;
            S    = 4'b1111;
            ACKL = 1'b1;
            SHKL = 1'b1;
            SHS  = 2'b10;
            SHM  = AC0;
         end
         StDchk: begin
            SL = 3'd3;
            S  = 4'b0110;
            C  = 1'b1;
         end
         StDshf: begin
            SL   = 3'd5;
            BC15 = SH15;
            M    = 1'b1;
            S    = 4'b1111;
            ACKL = 1'b1;
            SHKL = 1'b1;
            SHS  = 2'b01;
            SHX  = q_q;
         end
         StDtrl: begin
            SL   = 3'd3;
            S    = 4'b0110;
            C    = 1'b1;
            ACKL = CO | ext_q;
         end
         StDfin: begin
            SHKL = 1'b1;
            SHS  = 2'b01;
            SHX  = q_q;
         end
         default: ;
      endcase
   end

   assign busy = (state_q != StIdle);
   assign own  = busy;
   assign done = (state_q == StDone);
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: behavioural AMIN card model plus directed multiply/divide vectors.
module tb_muldiv_seq;

   logic        clk = 1'b0;
   logic        MCL, start, op;
   logic        CO, AC0, AC15, SH0, SH15;
   logic        own, busy, done, ovf, ACKL, SHKL, M, C, BC0, BC15, SHM, SHX;
   logic [1:0]  SHS;
   logic [2:0]  SL;
   logic [3:0]  S;

   logic [15:0] a_r, ac_r, sh_r, b_bus, f_bus;
   logic        co_r;
   logic        pre_ld;
   logic [15:0] pre_a, pre_ac, pre_sh;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   muldiv_seq #(.NBITS(16)) dut (
      .clk(clk), .MCL(MCL), .start(start), .op(op), .CO(CO),
      .AC0(AC0), .AC15(AC15), .SH0(SH0), .SH15(SH15),
      .own(own), .busy(busy), .done(done), .ovf(ovf),
      .ACKL(ACKL), .SHKL(SHKL), .M(M), .C(C), .BC0(BC0), .BC15(BC15),
      .SHM(SHM), .SHX(SHX), .SHS(SHS), .SL(SL), .S(S)
   );

   // Card model: B-source mux, ALU, AC and SH registers
   always_comb begin
      case (SL)
         3'd3:    b_bus = a_r;
         3'd4:    b_bus = {BC0, ac_r[15:1]};
         3'd5:    b_bus = {ac_r[14:0], BC15};
         default: b_bus = 16'h0000;
      endcase
      {co_r, f_bus} = 17'h0;
      if (M && S == 4'b1111)
         f_bus = b_bus;
      else if (!M && S == 4'b0001 && !C)
         {co_r, f_bus} = {1'b0, ac_r} + {1'b0, b_bus};
      else if (!M && S == 4'b0110 && C)
         {co_r, f_bus} = {1'b0, ac_r} + {1'b0, ~b_bus} + 17'd1;
   end

   assign CO   = co_r;
   assign AC0  = ac_r[0];
   assign AC15 = ac_r[15];
   assign SH0  = sh_r[0];
   assign SH15 = sh_r[15];

   always @(posedge clk) begin
      if (pre_ld) begin
         a_r  <= pre_a;
         ac_r <= pre_ac;
         sh_r <= pre_sh;
      end else begin
         if (ACKL) ac_r <= f_bus;
         if (SHKL) begin
            if (SHS == 2'b01) sh_r <= {sh_r[14:0], SHX};
            else if (SHS == 2'b10) sh_r <= {SHM, sh_r[15:1]};
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ctrl_vec();
      return {15'd0, ACKL, SHKL, M, C, BC0, BC15, SHM, SHX, SHS, SL, S};
   endfunction

   task automatic preload(input logic [15:0] a, input logic [15:0] ac, input logic [15:0] sh);
      @(negedge clk);
      pre_a  = a;
      pre_ac = ac;
      pre_sh = sh;
      pre_ld = 1'b1;
      @(negedge clk);
      pre_ld = 1'b0;
   endtask

   // Start an operation, find the done cycle, check results; stray_at>0 injects a start mid-run
   task automatic run_op(input string tag, input logic op_v, input int exp_cyc,
                         input logic exp_ovf, input logic [15:0] exp_ac,
                         input logic [15:0] exp_sh, input int stray_at);
      int cyc;
      int done_cyc;
      @(negedge clk);
      start = 1'b1;
      op    = op_v;
      @(negedge clk);
      start = 1'b0;
      cyc   = 1;
      check({tag, " busy"}, {30'd0, busy, own}, 32'h3);
      done_cyc = -1;
      while (done_cyc < 0 && cyc < 100) begin
         if (done) begin
            done_cyc = cyc;
         end else begin
            start = (cyc == stray_at);
            op    = ~op_v;
            @(negedge clk);
            start = 1'b0;
            cyc++;
         end
      end
      check({tag, " done cycle"}, done_cyc, exp_cyc);
      if (done_cyc < 0) begin
         MCL = 1'b1;
         @(negedge clk);
         MCL = 1'b0;
      end else begin
         check({tag, " ovf"}, {31'd0, ovf}, {31'd0, exp_ovf});
         check({tag, " AC"}, {16'd0, ac_r}, {16'd0, exp_ac});
         check({tag, " SH"}, {16'd0, sh_r}, {16'd0, exp_sh});
         check({tag, " ctrl in DONE"}, ctrl_vec(), 32'd0);
         // start in the DONE cycle must be ignored
         start = 1'b1;
         op    = op_v;
         @(negedge clk);
         start = 1'b0;
         check({tag, " idle after DONE"}, {29'd0, busy, own, done}, 32'd0);
      end
   endtask

   initial begin
      int done_seen;
      MCL    = 1'b1;
      start  = 1'b0;
      op     = 1'b0;
      pre_ld = 1'b0;
      pre_a  = 16'h0;
      pre_ac = 16'h0;
      pre_sh = 16'h0;
      #1;
      check("reset flags", {28'd0, own, busy, done, ovf}, 32'd0);
      check("reset ctrl", ctrl_vec(), 32'd0);
      @(negedge clk);
      MCL = 1'b0;
      @(negedge clk);
      check("idle flags", {28'd0, own, busy, done, ovf}, 32'd0);

      preload(16'h0007, 16'h1234, 16'h0009);
      run_op("mul 7*9", 1'b0, 34, 1'b0, 16'h0000, 16'h003F, 5);
      preload(16'hFFFF, 16'h0000, 16'hFFFF);
      run_op("mul ffff*ffff", 1'b0, 34, 1'b0, 16'hFFFE, 16'h0001, -1);
      preload(16'h0007, 16'h0000, 16'h0064);
      run_op("div 100/7", 1'b1, 35, 1'b0, 16'h0002, 16'h000E, -1);
      preload(16'hFFFF, 16'hFFFE, 16'h0001);
      run_op("div ext", 1'b1, 35, 1'b0, 16'h0000, 16'hFFFF, 12);
      preload(16'h0007, 16'h0007, 16'h1234);
      run_op("div ovf", 1'b1, 2, 1'b1, 16'h0007, 16'h1234, -1);
      preload(16'h0000, 16'h0000, 16'h5555);
      run_op("div by 0", 1'b1, 2, 1'b1, 16'h0000, 16'h5555, -1);
      preload(16'h0003, 16'h0001, 16'h0000);
      run_op("div 65536/3", 1'b1, 35, 1'b0, 16'h0001, 16'h5555, -1);

      // Master clear mid-multiply
      preload(16'h0007, 16'h0000, 16'h0009);
      @(negedge clk);
      start = 1'b1;
      op    = 1'b0;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      check("mcl busy before", {31'd0, busy}, 32'd1);
      MCL = 1'b1;
      #1;
      check("mcl abort flags", {29'd0, own, busy, done}, 32'd0);
      check("mcl abort ctrl", ctrl_vec(), 32'd0);
      @(negedge clk);
      MCL = 1'b0;
      done_seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done || busy) done_seen++;
      end
      check("mcl no done", done_seen, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
